// File: rtl/etroc2_pkg.sv
// Shared definitions for the ETROC2 frame parser: word field positions,
// frame error bit indices, CRC polynomial and parser state encoding.
package etroc2_pkg;

  localparam int unsigned WORD_W     = 40;
  localparam int unsigned HIT_W      = 59;
  localparam int unsigned ERR_W      = 5;
  localparam int unsigned HIT_CNT_W  = 9;

  localparam logic [17:0] HDR_PATTERN_DEFAULT = 18'h3C5C0;
  localparam logic [7:0]  CRC_POLY            = 8'h2F;

  // Header / filler fields
  localparam int unsigned HDR_PAT_MSB   = 39;
  localparam int unsigned HDR_PAT_LSB   = 22;
  localparam int unsigned HDR_L1_MSB    = 21;
  localparam int unsigned HDR_L1_LSB    = 14;
  localparam int unsigned HDR_TYPE_MSB  = 13;
  localparam int unsigned HDR_TYPE_LSB  = 12;
  localparam int unsigned HDR_BCID_MSB  = 11;
  localparam int unsigned HDR_BCID_LSB  = 0;
  localparam logic [1:0]  HDR_TYPE_FILLER = 2'b11;

  // Data fields
  localparam int unsigned DATA_FLAG_BIT    = 39;
  localparam int unsigned DATA_PAYLOAD_MSB = 38;

  // Trailer fields
  localparam int unsigned TRL_CHIP_MSB = 39;
  localparam int unsigned TRL_CHIP_LSB = 23;
  localparam int unsigned TRL_HITS_MSB = 16;
  localparam int unsigned TRL_HITS_LSB = 9;
  localparam int unsigned TRL_CRC_MSB  = 7;
  localparam int unsigned TRL_CRC_LSB  = 0;

  // frame_err bit indices
  localparam int unsigned ERR_CRC      = 4;
  localparam int unsigned ERR_CHIPID   = 3;
  localparam int unsigned ERR_HITCNT   = 2;
  localparam int unsigned ERR_OVERFLOW = 1;
  localparam int unsigned ERR_TRUNC    = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } state_t;

endpackage

// File: rtl/etroc2_frame_parser_if.sv
// Word stream from the aligner plus decoded hit / frame-status outputs.
interface etroc2_frame_parser_if;
  import etroc2_pkg::*;

  logic                 dataValid;
  logic                 aligned;
  logic [WORD_W-1:0]    din;
  logic                 hit_valid;
  logic [HIT_W-1:0]     hit_data;
  logic                 frame_done;
  logic                 frame_ok;
  logic [ERR_W-1:0]     frame_err;
  logic [HIT_CNT_W-1:0] frame_hits;

  modport master (
    output dataValid, aligned, din,
    input  hit_valid, hit_data, frame_done, frame_ok, frame_err, frame_hits
  );

  modport slave (
    input  dataValid, aligned, din,
    output hit_valid, hit_data, frame_done, frame_ok, frame_err, frame_hits
  );
endinterface

// File: rtl/etroc2_crc8.sv
// Combinational CRC-8 (poly 0x2F, MSB first) advance over a 40-bit word,
// or over its upper 32 bits when len32 is set.
module etroc2_crc8
  import etroc2_pkg::*;
(
  input  logic [7:0]        crc_in,
  input  logic [WORD_W-1:0] word,
  input  logic              len32,
  output logic [7:0]        crc_out
);

  // Bit-serial shift unrolled over the word, MSB first
  always_comb begin
    logic fb;
    crc_out = crc_in;
    fb      = 1'b0;
    for (int unsigned i = 0; i < WORD_W; i++) begin
      if (!len32 || i < 32) begin
        fb      = crc_out[7] ^ word[WORD_W-1-i];
        crc_out = {crc_out[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
      end
    end
  end

endmodule

// File: rtl/etroc2_frame_parser.sv
// ETROC2 frame parser: classifies aligned words, emits hit records tagged
// with L1/BCID, checks frames (chip ID, hit count, CRC-8) and keeps
// saturating statistics counters.
module etroc2_frame_parser
  import etroc2_pkg::*;
#(
  parameter logic [17:0] HDR_PATTERN = HDR_PATTERN_DEFAULT,
  parameter logic [16:0] CHIP_ID     = 17'h00000,
  parameter int unsigned MAX_HITS    = 256,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                  clk40,
  input  logic                  reset,
  etroc2_frame_parser_if.slave  fp,
  input  logic                  cnt_clear,
  output logic [CNT_W-1:0]      good_frames,
  output logic [CNT_W-1:0]      error_frames,
  output logic [CNT_W-1:0]      orphan_words
);

  state_t                 state_q, state_d;
  logic [7:0]             l1_q, l1_d;
  logic [11:0]            bcid_q, bcid_d;
  logic [HIT_CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic [7:0]             crc_q, crc_d;
  logic                   hit_valid_q, hit_valid_d;
  logic [HIT_W-1:0]       hit_data_q, hit_data_d;
  logic                   frame_done_q, frame_done_d;
  logic                   frame_ok_q, frame_ok_d;
  logic [ERR_W-1:0]       frame_err_q, frame_err_d;
  logic [HIT_CNT_W-1:0]   frame_hits_q, frame_hits_d;
  logic [CNT_W-1:0]       good_q, good_d;
  logic [CNT_W-1:0]       errf_q, errf_d;
  logic [CNT_W-1:0]       orph_q, orph_d;

  logic                   is_hdr, is_filler, is_data, is_trl;
  logic [7:0]             crc_seed, crc_next;
  logic                   open_frame, finish, orph_inc;
  logic [ERR_W-1:0]       fin_err;

  // Word classification and CRC seed selection
  always_comb begin
    is_hdr    = (fp.din[HDR_PAT_MSB:HDR_PAT_LSB] == HDR_PATTERN);
    is_filler = is_hdr && (fp.din[HDR_TYPE_MSB:HDR_TYPE_LSB] == HDR_TYPE_FILLER);
    is_data   = !is_hdr && fp.din[DATA_FLAG_BIT];
    is_trl    = !is_hdr && !fp.din[DATA_FLAG_BIT];
    crc_seed  = is_hdr ? 8'h00 : crc_q;
  end

  etroc2_crc8 u_crc (
    .crc_in  (crc_seed),
    .word    (fp.din),
    .len32   (is_trl),
    .crc_out (crc_next)
  );

  // Next-state, hit/frame outputs and statistics counters
  always_comb begin
    state_d      = state_q;
    l1_d         = l1_q;
    bcid_d       = bcid_q;
    hit_cnt_d    = hit_cnt_q;
    crc_d        = crc_q;
    hit_valid_d  = 1'b0;
    hit_data_d   = hit_data_q;
    frame_done_d = 1'b0;
    frame_ok_d   = frame_ok_q;
    frame_err_d  = frame_err_q;
    frame_hits_d = frame_hits_q;
    good_d       = good_q;
    errf_d       = errf_q;
    orph_d       = orph_q;
    open_frame   = 1'b0;
    finish       = 1'b0;
    orph_inc     = 1'b0;
    fin_err      = '0;

    if (fp.dataValid) begin
      if (!fp.aligned) begin
        if (state_q == FRAME) begin
          finish             = 1'b1;
          fin_err[ERR_TRUNC] = 1'b1;
          state_d            = IDLE;
        end
      end else begin
        unique case (state_q)
          IDLE: begin
            if (is_hdr) begin
              open_frame = !is_filler;
            end else begin
              orph_inc = 1'b1;
            end
          end
          FRAME: begin
            if (is_hdr) begin
              // A new header closes the open frame as truncated and
              // reopens on the same word.
              if (!is_filler) begin
                finish             = 1'b1;
                fin_err[ERR_TRUNC] = 1'b1;
                open_frame         = 1'b1;
              end
            end else if (is_data) begin
              if (hit_cnt_q == HIT_CNT_W'(MAX_HITS)) begin
                finish                = 1'b1;
                fin_err[ERR_OVERFLOW] = 1'b1;
                state_d               = IDLE;
              end else begin
                hit_valid_d = 1'b1;
                hit_data_d  = {l1_q, bcid_q, fp.din[DATA_PAYLOAD_MSB:0]};
                hit_cnt_d   = hit_cnt_q + HIT_CNT_W'(1);
                crc_d       = crc_next;
              end
            end else begin
              finish              = 1'b1;
              fin_err[ERR_CRC]    = (crc_next != fp.din[TRL_CRC_MSB:TRL_CRC_LSB]);
              fin_err[ERR_CHIPID] = (fp.din[TRL_CHIP_MSB:TRL_CHIP_LSB] != CHIP_ID);
              fin_err[ERR_HITCNT] = (fp.din[TRL_HITS_MSB:TRL_HITS_LSB] != hit_cnt_q[7:0]);
              state_d             = IDLE;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end

    if (open_frame) begin
      state_d   = FRAME;
      l1_d      = fp.din[HDR_L1_MSB:HDR_L1_LSB];
      bcid_d    = fp.din[HDR_BCID_MSB:HDR_BCID_LSB];
      hit_cnt_d = '0;
      crc_d     = crc_next;
    end

    if (finish) begin
      frame_done_d = 1'b1;
      frame_err_d  = fin_err;
      frame_ok_d   = (fin_err == '0);
      frame_hits_d = hit_cnt_q;
    end

    if (cnt_clear) begin
      good_d = '0;
      errf_d = '0;
      orph_d = '0;
    end else begin
      if (finish && (fin_err == '0) && (good_q != '1)) good_d = good_q + CNT_W'(1);
      if (finish && (fin_err != '0) && (errf_q != '1)) errf_d = errf_q + CNT_W'(1);
      if (orph_inc && (orph_q != '1))                  orph_d = orph_q + CNT_W'(1);
    end
  end

  // State and output registers
  always_ff @(posedge clk40 or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      l1_q         <= '0;
      bcid_q       <= '0;
      hit_cnt_q    <= '0;
      crc_q        <= '0;
      hit_valid_q  <= 1'b0;
      hit_data_q   <= '0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      frame_err_q  <= '0;
      frame_hits_q <= '0;
      good_q       <= '0;
      errf_q       <= '0;
      orph_q       <= '0;
    end else begin
      state_q      <= state_d;
      l1_q         <= l1_d;
      bcid_q       <= bcid_d;
      hit_cnt_q    <= hit_cnt_d;
      crc_q        <= crc_d;
      hit_valid_q  <= hit_valid_d;
      hit_data_q   <= hit_data_d;
      frame_done_q <= frame_done_d;
      frame_ok_q   <= frame_ok_d;
      frame_err_q  <= frame_err_d;
      frame_hits_q <= frame_hits_d;
      good_q       <= good_d;
      errf_q       <= errf_d;
      orph_q       <= orph_d;
    end
  end

  assign fp.hit_valid  = hit_valid_q;
  assign fp.hit_data   = hit_data_q;
  assign fp.frame_done = frame_done_q;
  assign fp.frame_ok   = frame_ok_q;
  assign fp.frame_err  = frame_err_q;
  assign fp.frame_hits = frame_hits_q;
  assign good_frames   = good_q;
  assign error_frames  = errf_q;
  assign orphan_words  = orph_q;

endmodule

// File: tb/tb_etroc2_frame_parser.sv
// Self-checking bench for etroc2_frame_parser: table of frame scenarios plus
// hand-written multi-cycle sequences; hits and frame results go through
// expectation queues. A second, narrow-counter instance sees the same
// traffic to exercise counter saturation.
module tb_etroc2_frame_parser;

  localparam logic [17:0] HDR  = 18'h3C5C0;
  localparam logic [16:0] CHIP = 17'h00000;

  logic clk40 = 1'b0;
  logic reset = 1'b0;
  logic cnt_clear = 1'b0;
  logic [15:0] good_frames, error_frames, orphan_words;
  logic [2:0]  good_s, error_s, orphan_s;

  etroc2_frame_parser_if bus ();
  etroc2_frame_parser_if bus_s ();

  assign bus_s.dataValid = bus.dataValid;
  assign bus_s.aligned   = bus.aligned;
  assign bus_s.din       = bus.din;

  etroc2_frame_parser #(.HDR_PATTERN(HDR), .CHIP_ID(CHIP), .MAX_HITS(256), .CNT_W(16)) dut (
    .clk40(clk40), .reset(reset), .fp(bus), .cnt_clear(cnt_clear),
    .good_frames(good_frames), .error_frames(error_frames), .orphan_words(orphan_words)
  );

  etroc2_frame_parser #(.HDR_PATTERN(HDR), .CHIP_ID(CHIP), .MAX_HITS(256), .CNT_W(3)) dut_s (
    .clk40(clk40), .reset(reset), .fp(bus_s), .cnt_clear(cnt_clear),
    .good_frames(good_s), .error_frames(error_s), .orphan_words(orphan_s)
  );

  always #5 clk40 = ~clk40;

  typedef struct { logic [58:0] data; int unsigned due; } hit_exp_t;
  typedef struct { logic [4:0] err; logic [8:0] hits; int unsigned due; } frm_exp_t;
  typedef struct {
    logic [7:0] l1; logic [11:0] bcid; int unsigned ndata;
    logic [16:0] chip; logic [7:0] hits; logic flip;
    logic [4:0] err; logic [8:0] exp_hits;
  } frame_vec_t;

  hit_exp_t hit_q[$];
  frm_exp_t frm_q[$];

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  int unsigned last_due = 0;
  longint unsigned tot_good = 0, tot_err = 0, tot_orph = 0;
  logic [7:0]  cur_l1, cur_bcid_lo;
  logic [11:0] cur_bcid;
  logic [7:0]  cur_crc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] crc_upd(input logic [7:0] c, input logic [39:0] w, input int n);
    logic [7:0] r;
    logic fb;
    r = c;
    for (int i = 39; i > 39 - n; i--) begin
      fb = r[7] ^ w[i];
      r  = {r[6:0], 1'b0};
      if (fb) r = r ^ 8'h2F;
    end
    return r;
  endfunction

  function automatic longint unsigned sat(input longint unsigned v, input longint unsigned m);
    return (v > m) ? m : v;
  endfunction

  always @(posedge clk40) cyc++;

  // Output monitor: pops expectations when strobes fire, flags missing ones
  always @(posedge clk40) begin
    hit_exp_t he;
    frm_exp_t fe;
    #1;
    if (bus.hit_valid) begin
      if (hit_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL hit_unexpected: got hit_data %0h expected no hit (cycle %0d)", bus.hit_data, cyc);
      end else begin
        he = hit_q.pop_front();
        chk("hit_data", 64'(bus.hit_data), 64'(he.data));
        chk("hit_latency", 64'(cyc), 64'(he.due));
      end
    end else if (hit_q.size() != 0 && hit_q[0].due <= cyc) begin
      he = hit_q.pop_front();
      checks++; errors++;
      $display("FAIL hit_missing: got no hit expected %0h at cycle %0d", he.data, he.due);
    end
    if (bus.frame_done) begin
      if (frm_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL frame_unexpected: got frame_done err %0b expected none (cycle %0d)", bus.frame_err, cyc);
      end else begin
        fe = frm_q.pop_front();
        chk("frame_err", 64'(bus.frame_err), 64'(fe.err));
        chk("frame_ok", 64'(bus.frame_ok), 64'(fe.err == 5'b0));
        chk("frame_hits", 64'(bus.frame_hits), 64'(fe.hits));
        chk("frame_latency", 64'(cyc), 64'(fe.due));
      end
    end else if (frm_q.size() != 0 && frm_q[0].due <= cyc) begin
      fe = frm_q.pop_front();
      checks++; errors++;
      $display("FAIL frame_missing: got no frame_done expected err %0b at cycle %0d", fe.err, fe.due);
    end
  end

  task automatic word(input logic dv, input logic al, input logic [39:0] w, input logic clr);
    @(negedge clk40);
    bus.dataValid = dv;
    bus.aligned   = al;
    bus.din       = w;
    cnt_clear     = clr;
    last_due      = cyc + 1;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) word(1'b0, 1'b1, 40'h0, 1'b0);
  endtask

  task automatic exp_frame(input logic [4:0] err, input logic [8:0] hits);
    frm_exp_t fe;
    fe.err = err; fe.hits = hits; fe.due = last_due;
    frm_q.push_back(fe);
    if (err == 5'b0) tot_good++; else tot_err++;
  endtask

  task automatic hdr(input logic [7:0] l1, input logic [11:0] bcid);
    logic [39:0] w;
    w = {HDR, l1, 2'b00, bcid};
    word(1'b1, 1'b1, w, 1'b0);
    cur_l1 = l1; cur_bcid = bcid;
    cur_crc = crc_upd(8'h00, w, 40);
  endtask

  function automatic logic [39:0] rand_data();
    logic [63:0] r;
    logic [39:0] w;
    r = {$urandom(), $urandom()};
    w = {1'b1, r[38:0]};
    if (w[39:22] == HDR) w[22] = ~w[22];
    return w;
  endfunction

  task automatic dat();
    hit_exp_t he;
    logic [39:0] w;
    w = rand_data();
    word(1'b1, 1'b1, w, 1'b0);
    he.data = {cur_l1, cur_bcid, w[38:0]};
    he.due  = last_due;
    hit_q.push_back(he);
    cur_crc = crc_upd(cur_crc, w, 40);
  endtask

  task automatic trl(input logic [16:0] chip, input logic [7:0] hits, input logic flip, input logic clr);
    logic [39:0] w;
    logic [7:0] c;
    w = {chip, 6'h00, hits, 1'b0, 8'h00};
    c = crc_upd(cur_crc, w, 32);
    w[7:0] = flip ? ~c : c;
    word(1'b1, 1'b1, w, clr);
  endtask

  task automatic check_counters(input string tag);
    idle(2);
    chk({tag, "_good"},   64'(good_frames),  64'(sat(tot_good, 16'hFFFF)));
    chk({tag, "_error"},  64'(error_frames), 64'(sat(tot_err, 16'hFFFF)));
    chk({tag, "_orphan"}, 64'(orphan_words), 64'(sat(tot_orph, 16'hFFFF)));
    chk({tag, "_good_sat"},   64'(good_s),   64'(sat(tot_good, 7)));
    chk({tag, "_error_sat"},  64'(error_s),  64'(sat(tot_err, 7)));
    chk({tag, "_orphan_sat"}, 64'(orphan_s), 64'(sat(tot_orph, 7)));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    frame_vec_t vecs[7];
    logic [39:0] w;

    vecs[0] = '{8'h12, 12'h345, 3, CHIP,     8'd3, 1'b0, 5'b00000, 9'd3};
    vecs[1] = '{8'h12, 12'h345, 3, CHIP,     8'd2, 1'b0, 5'b00100, 9'd3};
    vecs[2] = '{8'h12, 12'h345, 3, CHIP,     8'd3, 1'b1, 5'b10000, 9'd3};
    vecs[3] = '{8'h12, 12'h345, 3, 17'h1,    8'd3, 1'b0, 5'b01000, 9'd3};
    vecs[4] = '{8'h00, 12'h000, 0, CHIP,     8'd0, 1'b0, 5'b00000, 9'd0};
    vecs[5] = '{8'hFF, 12'hFFF, 5, 17'h1,    8'd5, 1'b1, 5'b11000, 9'd5};
    vecs[6] = '{8'h5A, 12'hA5A, 3, CHIP,     8'd4, 1'b0, 5'b00100, 9'd3};

    bus.dataValid = 1'b0;
    bus.aligned   = 1'b0;
    bus.din       = '0;
    repeat (3) @(negedge clk40);
    chk("rst_hit_valid",  64'(bus.hit_valid),  64'(0));
    chk("rst_hit_data",   64'(bus.hit_data),   64'(0));
    chk("rst_frame_done", 64'(bus.frame_done), 64'(0));
    chk("rst_frame_ok",   64'(bus.frame_ok),   64'(0));
    chk("rst_frame_err",  64'(bus.frame_err),  64'(0));
    chk("rst_frame_hits", 64'(bus.frame_hits), 64'(0));
    chk("rst_good",       64'(good_frames),    64'(0));
    chk("rst_error",      64'(error_frames),   64'(0));
    chk("rst_orphan",     64'(orphan_words),   64'(0));
    reset = 1'b1;
    idle(2);

    // Table of complete frames
    for (int unsigned i = 0; i < 7; i++) begin
      hdr(vecs[i].l1, vecs[i].bcid);
      for (int unsigned k = 0; k < vecs[i].ndata; k++) dat();
      trl(vecs[i].chip, vecs[i].hits, vecs[i].flip, 1'b0);
      exp_frame(vecs[i].err, vecs[i].exp_hits);
      idle(1);
    end
    check_counters("table");

    // Second header truncates the open frame and starts a new one
    hdr(8'h12, 12'h345); dat(); dat();
    hdr(8'hAB, 12'hCDE); exp_frame(5'b00001, 9'd2);
    dat();
    trl(CHIP, 8'd1, 1'b0, 1'b0); exp_frame(5'b00000, 9'd1);

    // Filler and an unqualified cycle inside a frame leave the CRC alone
    hdr(8'h33, 12'h044); dat();
    word(1'b1, 1'b1, {HDR, 8'h77, 2'b11, 12'h888}, 1'b0);
    word(1'b0, 1'b0, rand_data(), 1'b0);
    dat();
    trl(CHIP, 8'd2, 1'b0, 1'b0); exp_frame(5'b00000, 9'd2);

    // aligned drop mid-frame, then orphans and a filler while idle
    hdr(8'h44, 12'h055); dat();
    word(1'b1, 1'b0, rand_data(), 1'b0); exp_frame(5'b00001, 9'd1);
    word(1'b1, 1'b1, rand_data(), 1'b0); tot_orph++;
    w = {CHIP, 6'h00, 8'd0, 1'b0, 8'h00};
    word(1'b1, 1'b1, w, 1'b0); tot_orph++;
    word(1'b1, 1'b1, {HDR, 8'h01, 2'b11, 12'h002}, 1'b0);
    check_counters("seq");

    // Exactly MAX_HITS data words: still a good frame
    hdr(8'h66, 12'h077);
    repeat (256) dat();
    trl(CHIP, 8'h00, 1'b0, 1'b0); exp_frame(5'b00000, 9'd256);

    // MAX_HITS+1 data words: overflow abort, last word emits nothing
    hdr(8'h88, 12'h099);
    repeat (256) dat();
    word(1'b1, 1'b1, rand_data(), 1'b0); exp_frame(5'b00010, 9'd256);
    check_counters("maxhits");

    // Enough back-to-back good frames to saturate the narrow counters
    for (int unsigned i = 0; i < 6; i++) begin
      hdr(8'(i), 12'(i * 3));
      trl(CHIP, 8'd0, 1'b0, 1'b0); exp_frame(5'b00000, 9'd0);
    end
    check_counters("saturate");

    // cnt_clear coinciding with a frame finish: clear wins
    hdr(8'h9C, 12'h123); dat(); dat();
    trl(CHIP, 8'd2, 1'b0, 1'b1); exp_frame(5'b00000, 9'd2);
    word(1'b0, 1'b1, 40'h0, 1'b1);
    tot_good = 0; tot_err = 0; tot_orph = 0;
    check_counters("clear");

    hdr(8'h01, 12'h001); dat();
    trl(CHIP, 8'd1, 1'b0, 1'b0); exp_frame(5'b00000, 9'd1);
    check_counters("after_clear");

    idle(4);
    chk("hit_queue_drained",   64'(hit_q.size()), 64'(0));
    chk("frame_queue_drained", 64'(frm_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/etroc2_frame_parser.md
Name: etroc2_frame_parser

Overview:
- Sits directly downstream of the 40-bit word aligner; consumes its aligned 40-bit words, `aligned` flag and `dataValid` strobe on clk40.
- Classifies each word as header, data, trailer or filler and tracks frame boundaries.
- Emits one decoded hit record per data word, tagged with the frame's L1 counter and BCID.
- Checks each frame for chip ID, hit count and CRC-8, and keeps saturating good-frame and error counters for slow control.

Parameters:
- HDR_PATTERN, 18'h3C5C0, value required in word[39:22] for header/filler.
- CHIP_ID, 17'h00000, expected trailer chip ID.
- MAX_HITS, 256, maximum data words per frame before abort.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk40  in  1  40 MHz clock.
- reset  in  1  asynchronous, active-low reset.
- dataValid  in  1  word strobe; the block acts only on cycles where dataValid=1.
- aligned  in  1  upstream lock flag.
- din  in  40  aligned word.
- cnt_clear  in  1  synchronous clear of statistics counters.
- hit_valid  out  1  one-cycle hit strobe.
- hit_data  out  59  {L1[7:0], BCID[11:0], EA[1:0], col[3:0], row[3:0], TOA[9:0], TOT[8:0], CAL[9:0]}.
- frame_done  out  1  one-cycle strobe at frame end, good or bad.
- frame_ok  out  1  qualifies frame_done.
- frame_err  out  5  {crc, chipid, hitcnt, overflow, truncated}; valid with frame_done.
- frame_hits  out  9  data words counted in the finished frame.
- good_frames  out  CNT_W  saturating count.
- error_frames  out  CNT_W  saturating count.
- orphan_words  out  CNT_W  saturating count of data/trailer words seen outside a frame.

Behaviour:
- Reset: all outputs 0; state IDLE. Reset is asynchronous (clk40/negedge reset).
- Qualification: a word is processed only when dataValid & aligned. Otherwise nothing changes, except the aligned-drop rule below.
- Word classes:
  - HEADER/FILLER: din[39:22]==HDR_PATTERN. type=din[13:12]; type 2'b11 = filler, else header. L1=din[21:14], BCID=din[11:0].
  - DATA: din[39]==1.
  - TRAILER: din[39]==0 and not header pattern. chipid=din[39:23], status=din[22:17], hits=din[16:9], crc=din[7:0].
- State IDLE:
  - Header: latch L1/BCID, hit counter=0, CRC initialised from the header word → state FRAME.
  - Filler: ignored.
  - Data or trailer: orphan_words++, stay IDLE.
- State FRAME:
  - Data: hit_valid=1 next cycle with hit_data built from the latched L1/BCID plus din[38:0] fields; hit counter++; CRC updated.
  - If the hit counter would exceed MAX_HITS: abort with overflow=1, no hit emitted → IDLE.
  - Filler: ignored; CRC not updated.
  - Trailer: CRC updated over din[39:8] → finish. frame_err.crc = computed≠din[7:0]; chipid = mismatch; hitcnt = din[16:9]≠counter[7:0].
  - Header: finish with truncated=1, then immediately open the new frame on that same header (same cycle).
- Aligned drop: if aligned falls while in FRAME and dataValid=1, finish with truncated=1 → IDLE.
- Finish, registered, one cycle after the terminating word:
  - frame_done=1; frame_ok = (frame_err==0); frame_hits = counter.
  - good_frames or error_frames increments, saturating at all-ones.
- CRC-8: polynomial 0x2F, init 0x00, MSB-first, no reflection, no final XOR. Covers the header (40 bits), each data word (40 bits) and trailer bits [39:8], in arrival order.
- Counters:
  - cnt_clear zeroes all three counters.
  - If cnt_clear coincides with an increment, clear wins.
  - Counters hold at 2^CNT_W−1.
- Latency: hit_valid and frame_done assert exactly 1 clk40 after the qualifying input edge.
- Strobes are single-cycle pulses, not held.

Decomposition:
- Shared package etroc2_pkg:
  - HDR_PATTERN default.
  - Field bit-position localparams for header/data/trailer.
  - frame_err bit indices.
  - State encodings IDLE=1'b0, FRAME=1'b1.
- Sub-module etroc2_crc8: combinational next-CRC for a 40-bit word with a 32/40-bit length select.
- Statistics counters stay inline.

Test Plan:
- Header L1=8'h12, BCID=12'h345, three data words, then trailer with chipid=CHIP_ID, hits=3, correct CRC → 3 hit_valid pulses with hit_data[58:39]={8'h12,12'h345}; frame_done=1, frame_ok=1, frame_hits=3, good_frames=1.
- Same frame with trailer hits=2 → frame_err=5'b00100, error_frames=1; all 3 hits still emitted.
- Same frame with CRC byte flipped → frame_err=5'b10000; chip ID 17'h1 with CHIP_ID=0 → 5'b01000.
- Header, 2 data words, then a second header → frame_done with truncated (5'b00001), frame_hits=2; following frame parses normally with the new L1/BCID.
- aligned=0 mid-frame → truncated finish; data word while IDLE → orphan_words=1, no hit_valid; MAX_HITS+1 data words → overflow 5'b00010, exactly MAX_HITS hits emitted.
- Counter checks: force good_frames to 16'hFFFF, send one more good frame → stays 16'hFFFF. cnt_clear coinciding with frame_done → all counters 0.
